// File: rtl/luhn_digit_if.sv
// Digit-stream handshake between the deserialiser, the Luhn engine and the report logic.
interface luhn_digit_if;
   logic       in_valid;
   logic [3:0] in_num;
   logic       in_mode;
   logic       out_valid;
   logic [3:0] out;
   logic       out_ok;
   logic       out_err;

   modport master (
      output in_valid, in_num, in_mode,
      input  out_valid, out, out_ok, out_err
   );

   modport slave (
      input  in_valid, in_num, in_mode,
      output out_valid, out, out_ok, out_err
   );
endinterface

// File: rtl/luhn_digit_engine.sv
// Luhn mod-10 engine: one BCD digit per cycle, generates or verifies a check digit
// for a NUM_DIGITS payload, flags non-BCD digits, aborts on an in_valid gap.
//
// state  | meaning
// S_IDLE | waiting for the first digit of a frame (sum/err/cnt are zero)
// S_ACC  | accumulating digits 1..L-1 of the current frame
module luhn_digit_engine #(
   parameter int NUM_DIGITS = 15
) (
   input logic         clk,
   input logic         rst,
   luhn_digit_if.slave bus
);

   localparam int             CW       = $clog2(NUM_DIGITS + 2);
   localparam logic [CW-1:0]  LAST_GEN = CW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0]  LAST_VER = CW'(NUM_DIGITS);
   localparam logic           DBL_PAR  = 1'((NUM_DIGITS - 1) % 2);

   typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    sum;
   logic          err;
   logic          mode_q;

   logic          cur_mode;
   logic [CW-1:0] idx;
   logic [3:0]    base_sum;
   logic          base_err;
   logic          bad;
   logic          dbl;
   logic [3:0]    dval;
   logic [4:0]    sum_add;
   logic [3:0]    sum_nxt;
   logic          err_nxt;
   logic          is_last;
   logic [3:0]    res_out;

   always_comb begin
      cur_mode = (state == S_IDLE) ? bus.in_mode : mode_q;
      idx      = (state == S_IDLE) ? '0 : cnt;
      base_sum = (state == S_IDLE) ? 4'd0 : sum;
      base_err = (state == S_IDLE) ? 1'b0 : err;
      bad      = bus.in_num > 4'd9;
      // doubled iff (NUM_DIGITS-1-i) is even, i.e. i has the parity of NUM_DIGITS-1
      dbl      = (idx[0] == DBL_PAR);

      dval = 4'd0;
      if (!bad) begin
         if (dbl) begin
            case (bus.in_num)
               4'd0:    dval = 4'd0;
               4'd1:    dval = 4'd2;
               4'd2:    dval = 4'd4;
               4'd3:    dval = 4'd6;
               4'd4:    dval = 4'd8;
               4'd5:    dval = 4'd1;
               4'd6:    dval = 4'd3;
               4'd7:    dval = 4'd5;
               4'd8:    dval = 4'd7;
               default: dval = 4'd9;
            endcase
         end else begin
            dval = bus.in_num;
         end
      end

      sum_add = {1'b0, base_sum} + {1'b0, dval};
      sum_nxt = (sum_add >= 5'd10) ? 4'(sum_add - 5'd10) : sum_add[3:0];
      err_nxt = base_err | bad;
      is_last = (idx == (cur_mode ? LAST_VER : LAST_GEN));
      res_out = (sum_nxt == 4'd0) ? 4'd0 : (4'd10 - sum_nxt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         sum           <= 4'd0;
         err           <= 1'b0;
         mode_q        <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out       <= 4'd0;
         bus.out_ok    <= 1'b0;
         bus.out_err   <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         bus.out       <= 4'd0;
         bus.out_ok    <= 1'b0;
         bus.out_err   <= 1'b0;

         if (bus.in_valid) begin
            if (state == S_IDLE)
               mode_q <= bus.in_mode;
            if (is_last) begin
               bus.out_valid <= 1'b1;
               bus.out_err   <= err_nxt;
               bus.out_ok    <= !err_nxt && cur_mode && (sum_nxt == 4'd0);
               bus.out       <= (!err_nxt && !cur_mode) ? res_out : 4'd0;
               state         <= S_IDLE;
               cnt           <= '0;
               sum           <= 4'd0;
               err           <= 1'b0;
            end else begin
               state <= S_ACC;
               cnt   <= idx + CW'(1);
               sum   <= sum_nxt;
               err   <= err_nxt;
            end
         end else begin
            // a gap inside a frame abandons it; a gap in S_IDLE is just idle
            state <= S_IDLE;
            cnt   <= '0;
            sum   <= 4'd0;
            err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_luhn_digit_engine.sv
// Bench for luhn_digit_engine: three instances (10, 15 and 1 digits) checked every cycle
// against a frame-queue Luhn model, plus literal expectations for known vectors.
module tb_luhn_digit_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld = 1'b0;
   logic [3:0] num = 4'd0;
   logic       mode = 1'b0;
   logic [2:0] en = 3'b000;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   luhn_digit_if if_a ();
   luhn_digit_if if_b ();
   luhn_digit_if if_c ();

   assign if_a.in_valid = vld & en[0];
   assign if_a.in_num   = num;
   assign if_a.in_mode  = mode;
   assign if_b.in_valid = vld & en[1];
   assign if_b.in_num   = num;
   assign if_b.in_mode  = mode;
   assign if_c.in_valid = vld & en[2];
   assign if_c.in_num   = num;
   assign if_c.in_mode  = mode;

   luhn_digit_engine #(.NUM_DIGITS(10)) u_a (.clk(clk), .rst(rst), .bus(if_a));
   luhn_digit_engine #(.NUM_DIGITS(15)) u_b (.clk(clk), .rst(rst), .bus(if_b));
   luhn_digit_engine #(.NUM_DIGITS(1))  u_c (.clk(clk), .rst(rst), .bus(if_c));

   logic       dv [3];
   logic [3:0] dout [3];
   logic       dok [3];
   logic       derr [3];

   assign dv[0] = if_a.out_valid;  assign dout[0] = if_a.out;
   assign dok[0] = if_a.out_ok;    assign derr[0] = if_a.out_err;
   assign dv[1] = if_b.out_valid;  assign dout[1] = if_b.out;
   assign dok[1] = if_b.out_ok;    assign derr[1] = if_b.out_err;
   assign dv[2] = if_c.out_valid;  assign dout[2] = if_c.out;
   assign dok[2] = if_c.out_ok;    assign derr[2] = if_c.out_err;

   // ---------------- reference model ----------------
   int         ns [3] = '{10, 15, 1};
   logic [3:0] fd [3][32];
   int         fc [3] = '{0, 0, 0};
   bit         fm [3] = '{0, 0, 0};
   bit         ev [3] = '{0, 0, 0};
   logic [3:0] eo [3] = '{4'd0, 4'd0, 4'd0};
   bit         eok [3] = '{0, 0, 0};
   bit         eerr [3] = '{0, 0, 0};

   // returns {err, ok, out}
   function automatic logic [5:0] luhn(input logic [3:0] d [32], input int len, input int n,
                                       input bit m);
      int s = 0;
      bit e = 0;
      for (int i = 0; i < len; i++) begin
         int x = int'(d[i]);
         if (x > 9) e = 1;
         else if ((n - 1 - i) % 2 == 0) s += (2 * x > 9) ? 2 * x - 9 : 2 * x;
         else s += x;
      end
      s = s % 10;
      if (e) return {1'b1, 1'b0, 4'd0};
      if (m) return {1'b0, (s == 0), 4'd0};
      return {1'b0, 1'b0, 4'((10 - s) % 10)};
   endfunction

   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 3; k++) begin
         ev[k] = 0; eo[k] = 4'd0; eok[k] = 0; eerr[k] = 0;
         if (rst) fc[k] = 0;
         else if (vld && en[k]) begin
            logic [5:0] r;
            if (fc[k] == 0) fm[k] = mode;
            fd[k][fc[k]] = num;
            fc[k]++;
            if (fc[k] == ns[k] + int'(fm[k])) begin
               r = luhn(fd[k], fc[k], ns[k], fm[k]);
               ev[k] = 1; eerr[k] = r[5]; eok[k] = r[4]; eo[k] = r[3:0];
               fc[k] = 0;
            end
         end else fc[k] = 0;
      end
   end

   // ---------------- per-cycle compare and strobe log ----------------
   int         nlog [3] = '{0, 0, 0};
   logic [3:0] lo [3][512];
   logic       lok [3][512];
   logic       lerr [3][512];
   int         lcyc [3][512];

   always @(negedge clk) begin
      if (cyc >= 1) begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (dv[k] !== ev[k] || dout[k] !== eo[k] || dok[k] !== eok[k] || derr[k] !== eerr[k]) begin
               errors++;
               $display("FAIL cycle_cmp inst%0d cyc%0d: got v=%0b out=%0d ok=%0b err=%0b expected v=%0b out=%0d ok=%0b err=%0b",
                        k, cyc, dv[k], dout[k], dok[k], derr[k], ev[k], eo[k], eok[k], eerr[k]);
            end
            if (dv[k] === 1'b1) begin
               if (nlog[k] < 512) begin
                  lo[k][nlog[k]] = dout[k]; lok[k][nlog[k]] = dok[k];
                  lerr[k][nlog[k]] = derr[k]; lcyc[k][nlog[k]] = cyc;
               end
               nlog[k]++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [3:0] seq [$];

   task automatic lit(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drv(input bit v, input logic [3:0] d, input bit m);
      @(negedge clk);
      vld = v; num = d; mode = m;
   endtask

   task automatic send(input bit m);
      foreach (seq[i]) drv(1'b1, seq[i], m);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(1'b0, 4'd0, 1'b0);
   endtask

   task automatic load_a();
      seq = '{4'd7, 4'd9, 4'd9, 4'd2, 4'd7, 4'd3, 4'd9, 4'd8, 4'd7, 4'd1};
   endtask

   initial begin
      logic [3:0] pv [32];
      int b;
      int b2;

      foreach (pv[i]) pv[i] = 4'd0;
      pv[0] = 4'd7; pv[1] = 4'd9; pv[2] = 4'd9; pv[3] = 4'd2; pv[4] = 4'd7;
      pv[5] = 4'd3; pv[6] = 4'd9; pv[7] = 4'd8; pv[8] = 4'd7; pv[9] = 4'd1;
      lit("pin_model_gen", int'(luhn(pv, 10, 10, 1'b0)), 3);
      pv[10] = 4'd3;
      lit("pin_model_verify", int'(luhn(pv, 11, 10, 1'b1)), 16);

      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state
      lit("reset_out_valid", int'(dv[0] | dv[1] | dv[2]), 0);
      lit("reset_out", int'(dout[0] | dout[1]), 0);

      // generate, classic vector
      en = 3'b001; b = nlog[0];
      load_a(); send(1'b0); idle(3);
      lit("s1_count", nlog[0] - b, 1);
      lit("s1_out", int'(lo[0][b]), 3);
      lit("s1_ok", int'(lok[0][b]), 0);

      // verify pass then fail, back-to-back
      b = nlog[0];
      load_a(); seq.push_back(4'd3); send(1'b1);
      load_a(); seq.push_back(4'd0); send(1'b1);
      idle(3);
      lit("s2_count", nlog[0] - b, 2);
      lit("s2_ok_pass", int'(lok[0][b]), 1);
      lit("s2_ok_fail", int'(lok[0][b+1]), 0);
      lit("s2_spacing", lcyc[0][b+1] - lcyc[0][b], 11);

      // default length, all ones then all zeros
      en = 3'b010; b = nlog[1];
      seq = {}; repeat (15) seq.push_back(4'd1); send(1'b0);
      seq = {}; repeat (15) seq.push_back(4'd0); send(1'b0);
      idle(3);
      lit("s3_count", nlog[1] - b, 2);
      lit("s3_out_ones", int'(lo[1][b]), 7);
      lit("s3_out_zeros", int'(lo[1][b+1]), 0);

      // invalid digit in verify mode
      b = nlog[1];
      seq = {}; repeat (16) seq.push_back(4'd0); seq[3] = 4'hA; send(1'b1);
      idle(3);
      lit("s4_count", nlog[1] - b, 1);
      lit("s4_err", int'(lerr[1][b]), 1);
      lit("s4_ok", int'(lok[1][b]), 0);

      // abort after 5 digits, then a full frame
      en = 3'b001; b = nlog[0];
      seq = '{4'd7, 4'd9, 4'd9, 4'd2, 4'd7}; send(1'b0);
      idle(1);
      load_a(); send(1'b0); idle(3);
      lit("s5_count", nlog[0] - b, 1);
      lit("s5_out", int'(lo[0][b]), 3);

      // reset at digit 6 discards the frame
      b = nlog[0];
      seq = '{4'd7, 4'd9, 4'd9, 4'd2, 4'd7, 4'd3}; send(1'b0);
      @(negedge clk); rst = 1'b1; vld = 1'b1; num = 4'd9;
      @(negedge clk); rst = 1'b0; vld = 1'b0;
      idle(12);
      lit("s6_rst_nostrobe", nlog[0] - b, 0);

      // mode toggled mid-frame: latched mode governs
      b = nlog[0];
      load_a(); seq.push_back(4'd3);
      drv(1'b1, seq[0], 1'b1);
      for (int i = 1; i < 11; i++) drv(1'b1, seq[i], 1'b0);
      idle(2);
      load_a();
      drv(1'b1, seq[0], 1'b0);
      for (int i = 1; i < 10; i++) drv(1'b1, seq[i], 1'b1);
      idle(3);
      lit("s6_mode_count", nlog[0] - b, 2);
      lit("s6_mode_verify_ok", int'(lok[0][b]), 1);
      lit("s6_mode_gen_out", int'(lo[0][b+1]), 3);

      // single-digit frames back-to-back
      en = 3'b100; b = nlog[2];
      drv(1'b1, 4'd5, 1'b0); drv(1'b1, 4'd5, 1'b0);
      drv(1'b1, 4'd5, 1'b1); drv(1'b1, 4'd9, 1'b0);
      idle(3);
      lit("s7_count", nlog[2] - b, 3);
      lit("s7_gen_out", int'(lo[2][b]), 9);
      b2 = lcyc[2][b+1] - lcyc[2][b];
      lit("s7_spacing", b2, 1);
      lit("s7_verify_ok", int'(lok[2][b+2]), 1);

      // randomized stream into all three instances
      en = 3'b111;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst  = ($urandom_range(0, 299) == 0);
         vld  = ($urandom_range(0, 39) != 0);
         num  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         mode = 1'($urandom_range(0, 1));
      end
      idle(4);
      lit("rand_strobes_seen", int'(nlog[2] > 0 && nlog[0] > 0), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/luhn_digit_engine.md
# luhn_digit_engine

Parametrised Luhn (mod-10) engine for the digit-stream datapath: accepts one BCD digit per cycle, then either generates the check digit for an `NUM_DIGITS`-digit payload or verifies a payload plus check digit. Adds over the previous fixed 15-digit generator:
- configurable length;
- a verify mode;
- invalid-digit detection;
- frame abort;
- back-to-back frames.

It sits between the digit deserialiser and the result/report logic.

## Interface
- `NUM_DIGITS`, default 15: payload digit count, legal range 1..30.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_num` carries a digit this cycle.
- `in_num` input 4: digit, most-significant first; legal values 0..9.
- `in_mode` input 1: 0 = generate, 1 = verify. Sampled only on the first digit of a frame.
- `out_valid` output 1: one-cycle result strobe.
- `out` output 4: generate mode gives the check digit 0..9; verify mode gives 0.
- `out_ok` output 1: verify mode only, 1 = checksum correct and no bad digit; 0 in generate mode.
- `out_err` output 1: a digit > 9 was received in the frame.

## Operation
**Frame length.** L = `NUM_DIGITS` in generate mode, `NUM_DIGITS`+1 in verify mode. A frame is L consecutive cycles with `in_valid`=1.

**States.**
- IDLE, entered on reset:
  - `in_valid`=1 → latch `in_mode` into `mode_q`, process the digit at index i=0, go to ACC.
  - If L=1, go straight to the result.
- ACC: each `in_valid`=1 cycle processes the digit at index i=cnt. When i=L-1, the result is registered and the state returns to IDLE.

**Abort.** `in_valid`=0 while in ACC abandons the frame:
- clear cnt, sum and err;
- return to IDLE;
- no `out_valid`.

**Counter.** cnt is $clog2(`NUM_DIGITS`+2) bits and saturates at no value. It is cleared at end of frame, on abort, and on reset.

**Doubling rule.** The digit at index i is doubled iff (`NUM_DIGITS`-1-i) is even. This is the same rule in both modes, so the check digit at i=`NUM_DIGITS` is never doubled. Doubled value map: 0→0, 1→2, 2→4, 3→6, 4→8, 5→1, 6→3, 7→5, 8→7, 9→9.

**Running sum.** A 4-bit mod-10 value: sum_nxt = sum + d'; if sum_nxt ≥ 10, subtract 10. It is never ≥ 10 after an update.

**Invalid digit.** If `in_num` > 9:
- set err, sticky for the frame;
- add 0 to the sum for that digit;
- counting continues, so the frame length is unchanged.

**Results.**
- Generate: `out` = (10 − sum_final) mod 10.
- Verify: `out_ok` = (sum_final == 0) && !err.
- Any frame with err: `out_valid`=1, `out_err`=1, `out`=0, `out_ok`=0.

**Mode changes.** Changes to `in_mode` mid-frame are ignored; the latched `mode_q` governs the whole frame.

## Timing
- **Reset values.** Every output resets to 0: `out_valid`, `out`, `out_ok`, `out_err`. Internal cnt, sum, err, mode_q and state are cleared too.
- **Reset priority.** `rst`=1 at an edge overrides `in_valid`. A frame in progress is discarded with no output. The first frame may start on the first edge with `rst`=0.
- **Latency.** First digit at edge t0, last digit at edge t0+L-1. `out_valid` and the result outputs are registered and high in the cycle after edge t0+L-1, for exactly one cycle. At all other times `out`, `out_ok` and `out_err` are 0.
- **Back-to-back.** A new frame's first digit may arrive in the same cycle that `out_valid` is high, so the minimum spacing is L cycles. The sum restarts from 0, not from the previous result.
- **Throughput.** One digit per cycle, no stall.
- **Gap at a boundary.** `in_valid`=0 exactly at a frame boundary is idle, not an abort.

## Test plan
1. **Generate, classic vector.** `NUM_DIGITS`=10, mode 0, digits 7,9,9,2,7,3,9,8,7,1 → after 10 cycles `out_valid`=1 for one cycle, `out`=3, `out_ok`=0, `out_err`=0.
2. **Verify pass and fail, back-to-back.** `NUM_DIGITS`=10, mode 1:
   - 7,9,9,2,7,3,9,8,7,1,3 → `out_ok`=1.
   - Immediately followed by 7,9,9,2,7,3,9,8,7,1,0 → `out_ok`=0.
   - Expect two strobes exactly 11 cycles apart.
3. **Default length.** `NUM_DIGITS`=15, mode 0:
   - 15×1 → `out`=7.
   - Then 15×0 → `out`=0.
4. **Invalid digit.** `NUM_DIGITS`=15, mode 1, digit 4'hA at i=3, all others 0 → strobe after 16 digits with `out_err`=1, `out_ok`=0, `out`=0.
5. **Abort.** `in_valid` dropped after 5 digits, then a full frame as in scenario 1 → exactly one strobe, with `out`=3.
6. **Reset and mode change mid-frame.**
   - `rst` pulsed at digit 6 → no strobe, all outputs 0.
   - `in_mode` toggled mid-frame → result follows the mode latched on the first digit.
